// File: rtl/ff_conv_pkg.sv
// Shared mode encoding for the multi-mode flip-flop register bank.
package ff_conv_pkg;

    typedef logic [1:0] ff_mode_t;

    localparam ff_mode_t MODE_D  = 2'd0;
    localparam ff_mode_t MODE_T  = 2'd1;
    localparam ff_mode_t MODE_JK = 2'd2;
    localparam ff_mode_t MODE_SR = 2'd3;

endpackage : ff_conv_pkg

// File: rtl/ff_conv_reg_if.sv
// Bus bundle for ff_conv_reg: data/control inputs and all registered outputs.
//
// Mode-change handshake: the requester raises mode_req with mode; the request
// is taken on any rising edge where busy is low. The register then shows busy
// and a one-cycle mode_ack for exactly one cycle, during which q holds and any
// further mode_req is dropped (no queueing). Updates under the new mode begin
// on the edge after that.
interface ff_conv_reg_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
);
    import ff_conv_pkg::*;

    logic              en;
    logic [WIDTH-1:0]  a;
    logic [WIDTH-1:0]  b;
    logic              mode_req;
    ff_mode_t          mode;
    logic              err_clr;
    logic [WIDTH-1:0]  q;
    ff_mode_t          mode_cur;
    logic              busy;
    logic              mode_ack;
    logic              q_chg;
    logic [WIDTH-1:0]  err_bits;
    logic [CNT_W-1:0]  err_cnt;

    modport master (
        output en, a, b, mode_req, mode, err_clr,
        input  q, mode_cur, busy, mode_ack, q_chg, err_bits, err_cnt
    );

    modport slave (
        input  en, a, b, mode_req, mode, err_clr,
        output q, mode_cur, busy, mode_ack, q_chg, err_bits, err_cnt
    );

endinterface : ff_conv_reg_if

// File: rtl/ff_bit_cell.sv
// Combinational next-state logic for one bit of the multi-mode register.
module ff_bit_cell
    import ff_conv_pkg::*;
(
    input  logic     q_cur,
    input  logic     a,
    input  logic     b,
    input  ff_mode_t mode,
    input  logic     upd,
    output logic     q_next,
    output logic     ill
);

    // Select next state by mode; hold whenever no update is allowed.
    always_comb begin
        q_next = q_cur;
        ill    = 1'b0;
        if (upd) begin
            case (mode)
                MODE_D:  q_next = a;
                MODE_T:  q_next = q_cur ^ a;
                MODE_JK: begin
                    case ({a, b})
                        2'b00:   q_next = q_cur;
                        2'b01:   q_next = 1'b0;
                        2'b10:   q_next = 1'b1;
                        default: q_next = ~q_cur;
                    endcase
                end
                default: begin
                    // S=R=1 is illegal: keep the bit and report it.
                    case ({a, b})
                        2'b10:   q_next = 1'b1;
                        2'b01:   q_next = 1'b0;
                        2'b11:   ill    = 1'b1;
                        default: q_next = q_cur;
                    endcase
                end
            endcase
        end
    end

endmodule : ff_bit_cell

// File: rtl/ff_conv_reg.sv
// Multi-mode (D/T/JK/SR) register bank with clock enable, mode-change
// handshake, sticky SR-illegal flags and a saturating illegal-event counter.
module ff_conv_reg
    import ff_conv_pkg::*;
#(
    parameter int               WIDTH   = 4,
    parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}},
    parameter int               CNT_W   = 8
) (
    input  logic          clk,
    input  logic          rst,
    ff_conv_reg_if.slave  bus
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [WIDTH-1:0] q_q, q_d;
    ff_mode_t         mode_cur_q, mode_cur_d;
    logic             busy_q, busy_d;
    logic             mode_ack_q, mode_ack_d;
    logic             q_chg_q, q_chg_d;
    logic [WIDTH-1:0] err_bits_q, err_bits_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

    logic             upd;
    logic [WIDTH-1:0] q_next_w;
    logic [WIDTH-1:0] ill_w;
    logic             any_ill;

    assign upd     = bus.en & ~busy_q;
    assign any_ill = |ill_w;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        ff_bit_cell u_cell (
            .q_cur  (q_q[i]),
            .a      (bus.a[i]),
            .b      (bus.b[i]),
            .mode   (mode_cur_q),
            .upd    (upd),
            .q_next (q_next_w[i]),
            .ill    (ill_w[i])
        );
    end

    // Next state for data, change pulse and the one-cycle mode-settle handshake.
    always_comb begin
        q_d        = q_next_w;
        q_chg_d    = (q_next_w != q_q);
        mode_cur_d = mode_cur_q;
        busy_d     = 1'b0;
        mode_ack_d = 1'b0;
        if (bus.mode_req && !busy_q) begin
            mode_cur_d = bus.mode;
            busy_d     = 1'b1;
            mode_ack_d = 1'b1;
        end
    end

    // Sticky flags and saturating counter; a fresh event beats a same-cycle clear.
    always_comb begin
        err_bits_d = (bus.err_clr ? {WIDTH{1'b0}} : err_bits_q) | ill_w;
        err_cnt_d  = err_cnt_q;
        if (bus.err_clr) begin
            err_cnt_d = any_ill ? CNT_ONE : {CNT_W{1'b0}};
        end else if (any_ill && (err_cnt_q != CNT_MAX)) begin
            err_cnt_d = err_cnt_q + CNT_ONE;
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q        <= RST_VAL;
            mode_cur_q <= MODE_D;
            busy_q     <= 1'b0;
            mode_ack_q <= 1'b0;
            q_chg_q    <= 1'b0;
            err_bits_q <= {WIDTH{1'b0}};
            err_cnt_q  <= {CNT_W{1'b0}};
        end else begin
            q_q        <= q_d;
            mode_cur_q <= mode_cur_d;
            busy_q     <= busy_d;
            mode_ack_q <= mode_ack_d;
            q_chg_q    <= q_chg_d;
            err_bits_q <= err_bits_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign bus.q        = q_q;
    assign bus.mode_cur = mode_cur_q;
    assign bus.busy     = busy_q;
    assign bus.mode_ack = mode_ack_q;
    assign bus.q_chg    = q_chg_q;
    assign bus.err_bits = err_bits_q;
    assign bus.err_cnt  = err_cnt_q;

endmodule : ff_conv_reg
